calc_sequencer: RTL

Control state machine for the calculator datapath. Consumes the decoded keypad strobes: digit, operator and equals. It accumulates two 4-digit decimal operands, runs the selected operation as a multi-cycle binary computation, and converts the result to BCD. It drives the 16-bit BCD word shown on the 7-segment display. It sits between the keypad decoder and the display driver, and it replaces the combinational pass-through stage.

---
 rtl/calc_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven 4-digit BCD calculator controller with multi-cycle exec and BCD conversion.
// Define CALC_MUL_EN to build the shift-add multiplier; otherwise op 10 reports an error.
module calc_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  num_val,
   input  logic [1:0]  op_val,
   input  logic        is_num,
   input  logic        is_op,
   input  logic        is_eq,
   output logic [15:0] data_out_bcd,
   output logic        busy,
   output logic        done,
   output logic        err
);
   typedef enum logic [2:0] {ENTER_A, ENTER_B, EXEC, CONV, SHOW, ERROR} state_t;
   state_t      state;
   logic [13:0] a_bin, b_bin, res_bin, a_push, b_push, diff, exec_res;
   logic [15:0] a_bcd, b_bcd;
   logic [2:0]  a_cnt, b_cnt;
   logic [1:0]  op;
   logic [3:0]  cnt;
   logic [29:0] dd, dd_next;
   logic [14:0] sum;
   logic        num_ok, exec_err, exec_last;
`ifdef CALC_MUL_EN
   logic [27:0] prod, prod_next;
`endif

   // one double-dabble step: add-3 on each BCD digit >= 5, then shift {bcd, bin} left
   function automatic logic [29:0] dd_step(input logic [29:0] v);
      logic [29:0] t;
      t = v;
      for (int i = 0; i < 4; i++)
         t[14 + 4*i +: 4] = (t[14 + 4*i +: 4] >= 4'd5) ? t[14 + 4*i +: 4] + 4'd3 : t[14 + 4*i +: 4];
      return {t[28:0], 1'b0};
   endfunction

   assign num_ok  = num_val <= 4'd9;
   assign a_push  = a_bin * 14'd10 + {10'd0, num_val};
   assign b_push  = b_bin * 14'd10 + {10'd0, num_val};
   assign sum     = {1'b0, a_bin} + {1'b0, b_bin};
   assign diff    = a_bin - b_bin;
   assign dd_next = dd_step(dd);
`ifdef CALC_MUL_EN
   assign prod_next = prod + (b_bin[cnt] ? ({14'd0, a_bin} << cnt) : 28'd0);
`endif

   always_comb begin
      exec_res  = op[0] ? diff : sum[13:0];
      exec_err  = op[0] ? (a_bin < b_bin) : (sum > 15'd9999);
      exec_last = 1'b1;
`ifdef CALC_MUL_EN
      if (op == 2'b10) begin
         exec_res  = prod_next[13:0];
         exec_err  = prod_next > 28'd9999;
         exec_last = cnt == 4'd13;
      end
`else
      if (op == 2'b10) exec_err = 1'b1;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ENTER_A;
         a_bin        <= '0;
         b_bin        <= '0;
         res_bin      <= '0;
         a_bcd        <= '0;
         b_bcd        <= '0;
         a_cnt        <= '0;
         b_cnt        <= '0;
         op           <= '0;
         cnt          <= '0;
         dd           <= '0;
         data_out_bcd <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
`ifdef CALC_MUL_EN
         prod         <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            EXEC: begin
               cnt <= cnt + 4'd1;
`ifdef CALC_MUL_EN
               prod <= prod_next;
`endif
               if (exec_last) begin
                  cnt <= '0;
                  if (exec_err) begin
                     state        <= ERROR;
                     busy         <= 1'b0;
                     err          <= 1'b1;
                     data_out_bcd <= 16'hEEEE;
                  end else begin
                     state   <= CONV;
                     res_bin <= exec_res;
                     dd      <= {16'd0, exec_res};
                  end
               end
            end
            CONV: begin
               dd  <= dd_next;
               cnt <= cnt + 4'd1;
               if (cnt == 4'd13) begin
                  state        <= SHOW;
                  busy         <= 1'b0;
                  done         <= 1'b1;
                  data_out_bcd <= dd_next[29:14];
               end
            end
            default: begin
               if (is_num) begin
                  if (num_ok && state == ENTER_A && a_cnt != 3'd4) begin
                     a_bin        <= a_push;
                     a_bcd        <= {a_bcd[11:0], num_val};
                     a_cnt        <= a_cnt + 3'd1;
                     data_out_bcd <= {a_bcd[11:0], num_val};
                  end else if (num_ok && state == ENTER_B && b_cnt != 3'd4) begin
                     b_bin        <= b_push;
                     b_bcd        <= {b_bcd[11:0], num_val};
                     b_cnt        <= b_cnt + 3'd1;
                     data_out_bcd <= {b_bcd[11:0], num_val};
                  end else if (num_ok && (state == SHOW || state == ERROR)) begin
                     a_bin        <= {10'd0, num_val};
                     a_bcd        <= {12'd0, num_val};
                     a_cnt        <= 3'd1;
                     data_out_bcd <= {12'd0, num_val};
                     err          <= 1'b0;
                     state        <= ENTER_A;
                  end
               end else if (is_op && op_val == 2'b11) begin
                  state        <= ENTER_A;
                  a_bin        <= '0;
                  b_bin        <= '0;
                  a_bcd        <= '0;
                  b_bcd        <= '0;
                  a_cnt        <= '0;
                  b_cnt        <= '0;
                  op           <= '0;
                  data_out_bcd <= '0;
                  err          <= 1'b0;
               end else if (is_op && (state == ENTER_A || state == SHOW || (state == ENTER_B && b_cnt == 3'd0))) begin
                  op    <= op_val;
                  b_bin <= '0;
                  b_bcd <= '0;
                  b_cnt <= '0;
                  state <= ENTER_B;
                  if (state == SHOW) begin
                     a_bin <= res_bin;
                     a_bcd <= data_out_bcd;
                     a_cnt <= 3'd4;
                  end
               end else if (is_eq && state == ENTER_B) begin
                  state <= EXEC;
                  busy  <= 1'b1;
                  cnt   <= '0;
`ifdef CALC_MUL_EN
                  prod  <= '0;
`endif
               end
            end
         endcase
      end
   end
endmodule
